// File: rtl/uart_boot_loader.sv
// Parses a 4-byte LE length header from the UART byte stream, packs payload LE into 32-bit memory word writes.
// Latency: mem_we_o pulses one cycle after the byte that completes a word; done_o coincides with the last write.
// No backpressure: memory accepts every write; inter-byte silence of TIMEOUT_CYCLES aborts the transfer.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_BYTES      = 1024,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_LEN  = 32'(MAX_BYTES);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0] byte_idx_q, byte_idx_d;
    logic [29:0] word_idx_q, word_idx_d;
    logic [31:0] buf_q, buf_d;
    logic [3:0]  be_acc_q, be_acc_d;
    logic [31:0] tmo_q, tmo_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        in_xfer;
    logic        tmo_hit;
    logic [1:0]  lane;
    logic        last_byte;
    logic [31:0] full_len;
    logic [31:0] word_nxt;
    logic [3:0]  be_nxt;

    assign in_xfer   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_ERR);
    assign tmo_hit   = in_xfer && !rx_valid_i && (tmo_q == TMO_LAST);
    assign lane      = byte_idx_q[1:0];
    assign last_byte = (byte_idx_q == (len_q - 32'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hdr_cnt_d   = hdr_cnt_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        buf_d       = buf_q;
        be_acc_d    = be_acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        done_d      = done_q;
        err_d       = err_q;
        full_len    = {rx_data_i, len_q[23:0]};
        word_nxt    = buf_q;
        word_nxt[{lane, 3'b000} +: 8] = rx_data_i;
        be_nxt      = be_acc_q;
        be_nxt[lane] = 1'b1;

        // A byte in the same cycle as the timeout wins and restarts the count.
        if (!in_xfer || rx_valid_i || tmo_hit) begin
            tmo_d = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (rx_valid_i) begin
                    len_d     = {24'h0, rx_data_i};
                    hdr_cnt_d = 2'd1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid_i) begin
                    len_d[{hdr_cnt_q, 3'b000} +: 8] = rx_data_i;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (full_len == 32'd0) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else if (full_len > MAX_LEN) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            byte_idx_d = 32'd0;
                            word_idx_d = 30'd0;
                            buf_d      = 32'd0;
                            be_acc_d   = 4'd0;
                            state_d    = S_DATA;
                        end
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    byte_idx_d = byte_idx_q + 32'd1;
                    buf_d      = word_nxt;
                    be_acc_d   = be_nxt;
                    if ((lane == 2'd3) || last_byte) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {word_idx_q, 2'b00};
                        mem_wdata_d = word_nxt;
                        mem_be_d    = be_nxt;
                        buf_d       = 32'd0;
                        be_acc_d    = 4'd0;
                        word_idx_d  = word_idx_q + 30'd1;
                    end
                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (tmo_hit) begin
                    // Partial word is discarded rather than written.
                    buf_d    = 32'd0;
                    be_acc_d = 4'd0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ERR: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= 32'd0;
            hdr_cnt_q   <= 2'd0;
            byte_idx_q  <= 32'd0;
            word_idx_q  <= 30'd0;
            buf_q       <= 32'd0;
            be_acc_q    <= 4'd0;
            tmo_q       <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hdr_cnt_q   <= hdr_cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            buf_q       <= buf_d;
            be_acc_q    <= be_acc_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign busy_o      = in_xfer;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: header parsing, word packing, length errors, timeouts, reset.
// Writes are captured by a negedge monitor; each scenario task checks its own expected values.
module tb_uart_boot_loader;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int failed = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];

    uart_boot_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_BYTES      (1024),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wb_q.push_back(mem_be);
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wb_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        send_byte(len[23:16]);
        send_byte(len[31:24]);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            failed++;
            $display("FAIL reset_mem: we=%b addr=%h wdata=%h be=%h, want 0/0/0/0", mem_we, mem_addr, mem_wdata, mem_be);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failed++;
            $display("FAIL reset_status: busy=%b done=%b err=%b, want 0/0/0", busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_eight_bytes();
        logic [7:0] pl [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_log();
        send_hdr(32'd8);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL eight_busy: busy=%b, want 1", busy);
        end
        for (int i = 0; i < 8; i++) send_byte(pl[i]);
        tests++;
        if (mem_we !== 1'b1 || done !== 1'b1) begin
            failed++;
            $display("FAIL eight_last: we=%b done=%b, want 1/1", mem_we, done);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 2) begin
            failed++;
            $display("FAIL eight_count: writes=%0d, want 2", wa_q.size());
        end else begin
            tests++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h44332211 || wb_q[0] !== 4'hF) begin
                failed++;
                $display("FAIL eight_w0: addr=%h data=%h be=%h, want 0/44332211/f", wa_q[0], wd_q[0], wb_q[0]);
            end
            tests++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h88776655 || wb_q[1] !== 4'hF) begin
                failed++;
                $display("FAIL eight_w1: addr=%h data=%h be=%h, want 4/88776655/f", wa_q[1], wd_q[1], wb_q[1]);
            end
        end
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL eight_status: done=%b err=%b busy=%b, want 1/0/0", done, err, busy);
        end
    endtask

    task automatic test_five_bytes();
        logic [7:0] pl [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        clear_log();
        send_hdr(32'd5);
        for (int i = 0; i < 5; i++) send_byte(pl[i]);
        tests++;
        if (mem_we !== 1'b1 || done !== 1'b1) begin
            failed++;
            $display("FAIL five_last: we=%b done=%b, want 1/1", mem_we, done);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 2) begin
            failed++;
            $display("FAIL five_count: writes=%0d, want 2", wa_q.size());
        end else begin
            tests++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDDCCBBAA || wb_q[0] !== 4'hF) begin
                failed++;
                $display("FAIL five_w0: addr=%h data=%h be=%h, want 0/ddccbbaa/f", wa_q[0], wd_q[0], wb_q[0]);
            end
            tests++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h000000EE || wb_q[1] !== 4'h1) begin
                failed++;
                $display("FAIL five_w1: addr=%h data=%h be=%h, want 4/000000ee/1", wa_q[1], wd_q[1], wb_q[1]);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        send_byte(8'h00);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL zero_first: done=%b busy=%b, want 0/1", done, busy);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        tests++;
        if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL zero_done: done=%b we=%b busy=%b, want 1/0/0", done, mem_we, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (wa_q.size() != 0) begin
            failed++;
            $display("FAIL zero_writes: writes=%0d, want 0", wa_q.size());
        end
    endtask

    task automatic test_oversize();
        clear_log();
        send_hdr(32'd1025);
        tests++;
        if (err !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failed++;
            $display("FAIL over_err: err=%b busy=%b done=%b, want 1/1/0", err, busy, done);
        end
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (TMO - 1) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || wa_q.size() != 0) begin
            failed++;
            $display("FAIL over_hold: busy=%b writes=%0d, want 1/0", busy, wa_q.size());
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            failed++;
            $display("FAIL over_tmo: busy=%b err=%b, want 0/1", busy, err);
        end
        send_byte(8'h00);
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL over_clear: err=%b busy=%b, want 0/1", err, busy);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
    endtask

    task automatic test_timeout();
        clear_log();
        send_hdr(32'd6);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (TMO - 1) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failed++;
            $display("FAIL tmo_early: busy=%b err=%b, want 1/0", busy, err);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
            failed++;
            $display("FAIL tmo_hit: busy=%b err=%b done=%b, want 0/1/0", busy, err, done);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (wa_q.size() != 0) begin
            failed++;
            $display("FAIL tmo_writes: writes=%0d, want 0", wa_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_hdr(32'd8);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        #2 rst = 1'b1;
        #1;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            failed++;
            $display("FAIL rstmid_mem: we=%b addr=%h wdata=%h be=%h, want 0/0/0/0", mem_we, mem_addr, mem_wdata, mem_be);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_status: busy=%b done=%b err=%b, want 0/0/0", busy, done, err);
        end
        clear_log();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_hdr(32'd4);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
        tests++;
        if (mem_we !== 1'b1 || done !== 1'b1) begin
            failed++;
            $display("FAIL rstmid_last: we=%b done=%b, want 1/1", mem_we, done);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 1) begin
            failed++;
            $display("FAIL rstmid_count: writes=%0d, want 1", wa_q.size());
        end else begin
            tests++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hEFBEADDE || wb_q[0] !== 4'hF) begin
                failed++;
                $display("FAIL rstmid_w0: addr=%h data=%h be=%h, want 0/efbeadde/f", wa_q[0], wd_q[0], wb_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5};
        clear_log();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = seq[0];
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            rx_data = seq[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tests++;
        if (mem_we !== 1'b1 || done !== 1'b1) begin
            failed++;
            $display("FAIL b2b_last: we=%b done=%b, want 1/1", mem_we, done);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 1) begin
            failed++;
            $display("FAIL b2b_count: writes=%0d, want 1", wa_q.size());
        end else begin
            tests++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h0000A55A || wb_q[0] !== 4'h3) begin
                failed++;
                $display("FAIL b2b_w0: addr=%h data=%h be=%h, want 0/0000a55a/3", wa_q[0], wd_q[0], wb_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_eight_bytes();
        test_five_bytes();
        test_zero_len();
        test_oversize();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
